regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port (register A: address, write enable, write data) among N_REQ writeback requesters using a valid/ready handshake and round-robin priority. It also runs a clear sequence that walks all entries and writes zero. The block sits between the execution/load writeback sources and the register file, and drives the write port from a registered output stage.

## Interface
- REG_WIDTH, 34, register data width
- ADDR_WIDTH, 5, register address width; the register file holds 1<<ADDR_WIDTH entries
- N_REQ, 3, number of write requesters (2..8)
- GNT_W, 2, width of the grant index; must satisfy 2^GNT_W >= N_REQ

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active low
- i_req_valid  in  N_REQ  per-requester write request
- i_req_addr  in  N_REQ*ADDR_WIDTH  packed target addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_data  in  N_REQ*REG_WIDTH  packed write data; requester k occupies bits [k*REG_WIDTH +: REG_WIDTH]
- o_req_ready  out  N_REQ  one-hot grant; a request is accepted when valid and ready are both high
- i_clear_start  in  1  single-cycle pulse that starts the clear sequence
- o_busy  out  1  high while the clear sequence runs
- o_address_reg_a  out  ADDR_WIDTH  write address to the register file
- o_wenable_reg_a  out  1  write enable to the register file
- o_writedata_reg_a  out  REG_WIDTH  write data to the register file
- o_grant_id  out  GNT_W  index of the requester whose write is currently on the port

## Operation
- FSM states:
  - IDLE: arbitrate among requesters.
  - CLEAR: sequence zero writes to every entry.
- IDLE -> CLEAR when i_clear_start=1. CLEAR -> IDLE after the write to address (1<<ADDR_WIDTH)-1 is issued.
- Arbitration (IDLE only):
  - Search order starts at pointer rr_ptr and wraps modulo N_REQ.
  - The first valid requester found gets ready=1. All other ready outputs are 0.
  - o_req_ready is combinational from i_req_valid and rr_ptr. At most one bit is high.
  - After a grant to requester k, rr_ptr becomes (k+1) mod N_REQ. rr_ptr is unchanged in any cycle with no grant.
- Handshake rules:
  - A requester holds valid, addr and data stable until it sees ready.
  - A requester may not drop valid before acceptance.
  - Every accepted request produces exactly one write.
- Clear sequence:
  - A counter runs from 0 to (1<<ADDR_WIDTH)-1. One write of all-zero data is issued per cycle.
  - o_grant_id=0 during the sequence.
  - All o_req_ready bits are 0 during CLEAR.
  - i_clear_start is ignored while in CLEAR.
- Simultaneous i_clear_start and valid requests in IDLE: the clear wins, and no ready is asserted in that cycle.
- Unrequested cycles: o_wenable_reg_a=0. Address and data hold their last values.

## Timing
- Reset values: o_req_ready=0, o_busy=0, o_address_reg_a=0, o_wenable_reg_a=0, o_writedata_reg_a=0, o_grant_id=0, rr_ptr=0, state=IDLE, counter=0.
- A request accepted in cycle T appears on the write-port outputs in cycle T+1. It is written at the end of T+1 and is readable through the register file's combinational read ports in T+2.
- Clear:
  - Pulse in cycle T. o_busy is high from T+1 through T+32 (for ADDR_WIDTH=5).
  - Zero writes are presented in T+1..T+32, addresses ascending.
  - Ready may assert again starting in cycle T+32.
- Reset asserted mid-clear: immediate return to IDLE, counter=0, all outputs at reset values. The sequence does not resume.
- Throughput: one accepted write per cycle.

## Configuration
- Macro: RF_ARB_ZERO_PROTECT_EN.
- Defined:
  - Accepted requests to address 0 are still acknowledged with ready=1 and still advance rr_ptr.
  - o_wenable_reg_a stays 0 for those requests, so entry 0 always reads as zero.
  - Clear writes to address 0 are also suppressed.
- Undefined: address 0 is an ordinary writable entry.

## Structure
- Shared package/header `rf_ctrl_pkg`:
  - state encodings ST_IDLE=1'b0 and ST_CLEAR=1'b1
  - default REG_WIDTH and ADDR_WIDTH
  - N_REGISTERS=(1<<ADDR_WIDTH)
- One sub-module, `rr_arbiter`:
  - Combinational search over a valid vector, starting from a pointer.
  - Outputs the one-hot grant and the encoded index.
  - The pointer register stays in the parent block.

## Test plan
- Reset, then idle with no requests -> every output is 0. Requester 1 writes addr 7, data 34'h1_2345_6789 -> ready[1] high in T; in T+1, address=7, wenable=1, data=34'h1_2345_6789, grant_id=1.
- Requesters 0, 1 and 2 all hold valid for 6 cycles with distinct addresses -> grants in order 0,1,2,0,1,2 with one write per cycle.
- Requester 2 holds valid while ready is low -> address and data stay stable. Exactly one write is observed after ready.
- i_clear_start together with valid on requester 0 -> no ready in that cycle. o_busy is high for 32 cycles, with zero writes to addresses 0..31 in order. Requester 0 is granted in the final busy cycle.
- Reset asserted at clear step 10 -> all outputs reach reset values. A new clear afterwards starts again at address 0.
- With RF_ARB_ZERO_PROTECT_EN defined, a write to addr 0 with data 34'h3_FFFF_FFFF -> ready=1 and wenable stays 0. Without the macro -> wenable=1.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and state encoding for the register-file write control logic.
package rf_ctrl_pkg;

   localparam int DEFAULT_REG_WIDTH  = 34;
   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam int N_REGISTERS        = (1 << DEFAULT_ADDR_WIDTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } rf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: starting at ptr and wrapping modulo
// N_REQ, the first valid requester wins. The pointer itself lives in the parent.
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int GNT_W = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [GNT_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [GNT_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [GNT_W:0]   pos_s;
   logic [GNT_W-1:0] idx_s;
   logic             hit_s;

   // Walk the requesters in priority order and latch onto the first valid one
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      pos_s     = '0;
      idx_s     = '0;
      hit_s     = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         pos_s     = {1'b0, ptr} + (GNT_W+1)'(i);
         pos_s     = (pos_s >= (GNT_W+1)'(N_REQ)) ? (pos_s - (GNT_W+1)'(N_REQ)) : pos_s;
         idx_s     = pos_s[GNT_W-1:0];
         hit_s     = !grant_any && valid[idx_s];
         grant_idx = hit_s ? idx_s : grant_idx;
         grant[idx_s] = grant[idx_s] | hit_s;
         grant_any = grant_any | hit_s;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// clear sequence that writes zero to every entry. Write-port outputs are
// registered; o_req_ready is combinational from valid and the pointer.
// Optional build macro RF_ARB_ZERO_PROTECT_EN: entry 0 is never written.
module regfile_write_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int N_REQ      = 3,
   parameter int GNT_W      = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            i_req_valid,
   input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [N_REQ*REG_WIDTH-1:0]  i_req_data,
   output logic [N_REQ-1:0]            o_req_ready,
   input  logic                        i_clear_start,
   output logic                        o_busy,
   output logic [ADDR_WIDTH-1:0]       o_address_reg_a,
   output logic                        o_wenable_reg_a,
   output logic [REG_WIDTH-1:0]        o_writedata_reg_a,
   output logic [GNT_W-1:0]            o_grant_id
);

`ifdef RF_ARB_ZERO_PROTECT_EN
   localparam bit ZERO_PROTECT = 1'b1;
`else
   localparam bit ZERO_PROTECT = 1'b0;
`endif

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   // Write enable for a given target address; entry 0 is masked when protected
   function automatic logic write_allowed(input logic [ADDR_WIDTH-1:0] addr);
      return !(ZERO_PROTECT && (addr == {ADDR_WIDTH{1'b0}}));
   endfunction

   rf_state_e               state_r;
   logic [ADDR_WIDTH-1:0]   counter_r;
   logic [GNT_W-1:0]        rr_ptr_r;
   logic [ADDR_WIDTH-1:0]   address_r;
   logic                    wenable_r;
   logic [REG_WIDTH-1:0]    writedata_r;
   logic [GNT_W-1:0]        grant_id_r;
   logic                    busy_r;

   logic [N_REQ-1:0]        arb_grant_s;
   logic [GNT_W-1:0]        arb_idx_s;
   logic                    arb_any_s;
   logic                    arb_en_s;
   logic [ADDR_WIDTH-1:0]   sel_addr_s;
   logic [REG_WIDTH-1:0]    sel_data_s;
   logic [GNT_W-1:0]        ptr_next_s;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .GNT_W (GNT_W)
   ) u_rr_arbiter (
      .valid     (i_req_valid),
      .ptr       (rr_ptr_r),
      .grant     (arb_grant_s),
      .grant_idx (arb_idx_s),
      .grant_any (arb_any_s)
   );

   // Arbitration is live only in IDLE and loses to a clear request in the same cycle
   assign arb_en_s    = (state_r == ST_IDLE) && !i_clear_start;
   assign o_req_ready = arb_en_s ? arb_grant_s : {N_REQ{1'b0}};
   assign sel_addr_s  = i_req_addr[arb_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_data_s  = i_req_data[arb_idx_s*REG_WIDTH +: REG_WIDTH];
   assign ptr_next_s  = (arb_idx_s == GNT_W'(N_REQ - 1)) ? {GNT_W{1'b0}} : (arb_idx_s + GNT_W'(1));

   // Control FSM, round-robin pointer and registered write-port stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         counter_r   <= {ADDR_WIDTH{1'b0}};
         rr_ptr_r    <= {GNT_W{1'b0}};
         address_r   <= {ADDR_WIDTH{1'b0}};
         wenable_r   <= 1'b0;
         writedata_r <= {REG_WIDTH{1'b0}};
         grant_id_r  <= {GNT_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_clear_start) begin
                  // first clear write (address 0) goes out right away
                  state_r     <= ST_CLEAR;
                  counter_r   <= ADDR_WIDTH'(1);
                  address_r   <= {ADDR_WIDTH{1'b0}};
                  wenable_r   <= write_allowed({ADDR_WIDTH{1'b0}});
                  writedata_r <= {REG_WIDTH{1'b0}};
                  grant_id_r  <= {GNT_W{1'b0}};
                  busy_r      <= 1'b1;
               end else if (arb_any_s) begin
                  address_r   <= sel_addr_s;
                  wenable_r   <= write_allowed(sel_addr_s);
                  writedata_r <= sel_data_s;
                  grant_id_r  <= arb_idx_s;
                  rr_ptr_r    <= ptr_next_s;
                  busy_r      <= 1'b0;
               end else begin
                  // no write: address, data and grant id hold
                  wenable_r   <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            ST_CLEAR: begin
               address_r   <= counter_r;
               wenable_r   <= write_allowed(counter_r);
               writedata_r <= {REG_WIDTH{1'b0}};
               grant_id_r  <= {GNT_W{1'b0}};
               busy_r      <= 1'b1;
               if (counter_r == LAST_ADDR) begin
                  // last write is on its way out; arbitration resumes next cycle
                  state_r   <= ST_IDLE;
                  counter_r <= {ADDR_WIDTH{1'b0}};
               end else begin
                  counter_r <= counter_r + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               counter_r <= {ADDR_WIDTH{1'b0}};
               wenable_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy            = busy_r;
   assign o_address_reg_a   = address_r;
   assign o_wenable_reg_a   = wenable_r;
   assign o_writedata_reg_a = writedata_r;
   assign o_grant_id        = grant_id_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: constant vector table,
// directed multi-cycle sequences and randomized traffic against a queue-based model.
module tb_regfile_write_arbiter;

   localparam int N    = 3;
   localparam int AW   = 5;
   localparam int RW   = 34;
   localparam int GW   = 2;
   localparam int NENT = 1 << AW;

`ifdef RF_ARB_ZERO_PROTECT_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      i_req_valid;
   logic [N*AW-1:0]   i_req_addr;
   logic [N*RW-1:0]   i_req_data;
   logic [N-1:0]      o_req_ready;
   logic              i_clear_start;
   logic              o_busy;
   logic [AW-1:0]     o_address_reg_a;
   logic              o_wenable_reg_a;
   logic [RW-1:0]     o_writedata_reg_a;
   logic [GW-1:0]     o_grant_id;

   regfile_write_arbiter #(
      .REG_WIDTH (RW), .ADDR_WIDTH (AW), .N_REQ (N), .GNT_W (GW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_req_valid       (i_req_valid),
      .i_req_addr        (i_req_addr),
      .i_req_data        (i_req_data),
      .o_req_ready       (o_req_ready),
      .i_clear_start     (i_clear_start),
      .o_busy            (o_busy),
      .o_address_reg_a   (o_address_reg_a),
      .o_wenable_reg_a   (o_wenable_reg_a),
      .o_writedata_reg_a (o_writedata_reg_a),
      .o_grant_id        (o_grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: round-robin pointer as an integer, clear as a queue of pending addresses
   int          ptr_m;
   int          clr_q[$];
   logic [AW-1:0] e_addr;
   logic          e_wen;
   logic [RW-1:0] e_data;
   logic [GW-1:0] e_gid;
   logic          e_busy;
   logic [N-1:0]  last_rdy;
   logic [N-1:0]  last_dut_rdy;

   typedef struct {
      logic [N-1:0]    valid;
      logic [N*AW-1:0] addr;
      logic [N*RW-1:0] data;
      logic            clr;
      logic [N-1:0]    rdy;
      logic            wen;
      logic [AW-1:0]   waddr;
      logic [RW-1:0]   wdata;
      logic [GW-1:0]   gid;
      logic            busy;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      ptr_m = 0;
      clr_q.delete();
      e_addr = '0; e_wen = 1'b0; e_data = '0; e_gid = '0; e_busy = 1'b0;
   endtask

   task automatic model_cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                              input logic [N*RW-1:0] d, input logic c, output logic [N-1:0] rdy);
      int win;
      int a0;
      int k;
      rdy = '0;
      win = -1;
      if (clr_q.size() == 0 && c) begin
         for (int i = 0; i < NENT; i++) clr_q.push_back(i);
      end
      if (clr_q.size() != 0) begin
         a0     = clr_q.pop_front();
         e_addr = a0[AW-1:0];
         e_data = '0;
         e_wen  = !(ZP && a0 == 0);
         e_gid  = '0;
         e_busy = 1'b1;
      end else begin
         for (int o = 0; o < N; o++) begin
            k = (ptr_m + o) % N;
            if (win < 0 && v[k]) win = k;
         end
         e_busy = 1'b0;
         if (win >= 0) begin
            rdy[win] = 1'b1;
            ptr_m    = (win + 1) % N;
            e_addr   = a[win*AW +: AW];
            e_data   = d[win*RW +: RW];
            e_wen    = !(ZP && e_addr == '0);
            e_gid    = win[GW-1:0];
         end else begin
            e_wen = 1'b0;
         end
      end
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_addr"}, 64'(o_address_reg_a), 64'(e_addr));
      chk({tag, "_wen"},  64'(o_wenable_reg_a), 64'(e_wen));
      chk({tag, "_data"}, 64'(o_writedata_reg_a), 64'(e_data));
      chk({tag, "_gid"},  64'(o_grant_id), 64'(e_gid));
      chk({tag, "_busy"}, 64'(o_busy), 64'(e_busy));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, 64'(o_req_ready), 64'd0);
      chk({tag, "_busy"},  64'(o_busy), 64'd0);
      chk({tag, "_addr"},  64'(o_address_reg_a), 64'd0);
      chk({tag, "_wen"},   64'(o_wenable_reg_a), 64'd0);
      chk({tag, "_data"},  64'(o_writedata_reg_a), 64'd0);
      chk({tag, "_gid"},   64'(o_grant_id), 64'd0);
   endtask

   // One clock cycle: drive, check ready mid-cycle, check registered outputs after the edge
   task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N*RW-1:0] d, input logic c, input string tag);
      logic [N-1:0] er;
      i_req_valid   = v;
      i_req_addr    = a;
      i_req_data    = d;
      i_clear_start = c;
      model_cycle(v, a, d, c, er);
      last_rdy = er;
      @(negedge clk);
      last_dut_rdy = o_req_ready;
      chk({tag, "_ready"}, 64'(o_req_ready), 64'(er));
      @(posedge clk);
      #1;
      chk_outs(tag);
   endtask

   task automatic do_reset();
      i_req_valid = '0; i_req_addr = '0; i_req_data = '0; i_clear_start = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   logic [N*AW-1:0] av;
   logic [N*RW-1:0] dv;
   logic [N-1:0]    pv;
   logic [N*AW-1:0] pa;
   logic [N*RW-1:0] pd;
   int busy_cnt;
   int wcount;
   int grant_at;

   initial begin
      rst_n = 1'b0;
      model_reset();
      av = {5'd3, 5'd2, 5'd1};
      dv = {34'h2_0000_0003, 34'h1_0000_0002, 34'h0_0000_0001};
      //           valid   addr                     data                                          clr   rdy     wen   waddr  wdata             gid   busy
      tbl[0]  = '{3'b000, 15'd0, 102'd0,                                                      1'b0, 3'b000, 1'b0, 5'd0, 34'd0,            2'd0, 1'b0};
      tbl[1]  = '{3'b111, av,    dv,                                                          1'b0, 3'b001, 1'b1, 5'd1, 34'h0_0000_0001,  2'd0, 1'b0};
      tbl[2]  = '{3'b111, av,    dv,                                                          1'b0, 3'b010, 1'b1, 5'd2, 34'h1_0000_0002,  2'd1, 1'b0};
      tbl[3]  = '{3'b111, av,    dv,                                                          1'b0, 3'b100, 1'b1, 5'd3, 34'h2_0000_0003,  2'd2, 1'b0};
      tbl[4]  = '{3'b111, av,    dv,                                                          1'b0, 3'b001, 1'b1, 5'd1, 34'h0_0000_0001,  2'd0, 1'b0};
      tbl[5]  = '{3'b111, av,    dv,                                                          1'b0, 3'b010, 1'b1, 5'd2, 34'h1_0000_0002,  2'd1, 1'b0};
      tbl[6]  = '{3'b111, av,    dv,                                                          1'b0, 3'b100, 1'b1, 5'd3, 34'h2_0000_0003,  2'd2, 1'b0};
      tbl[7]  = '{3'b010, {5'd0, 5'd7, 5'd0}, {34'd0, 34'h1_2345_6789, 34'd0},               1'b0, 3'b010, 1'b1, 5'd7, 34'h1_2345_6789,  2'd1, 1'b0};
      tbl[8]  = '{3'b000, 15'd0, 102'd0,                                                      1'b0, 3'b000, 1'b0, 5'd7, 34'h1_2345_6789,  2'd1, 1'b0};
      tbl[9]  = '{3'b001, 15'd0, {34'd0, 34'd0, 34'h3_FFFF_FFFF},                             1'b0, 3'b001, 1'(!ZP), 5'd0, 34'h3_FFFF_FFFF, 2'd0, 1'b0};
      tbl[10] = '{3'b101, {5'd9, 5'd0, 5'd4}, {34'h0_AAAA_5555, 34'd0, 34'h1_5555_AAAA},     1'b0, 3'b100, 1'b1, 5'd9, 34'h0_AAAA_5555,  2'd2, 1'b0};
      tbl[11] = '{3'b101, {5'd9, 5'd0, 5'd4}, {34'h0_AAAA_5555, 34'd0, 34'h1_5555_AAAA},     1'b0, 3'b001, 1'b1, 5'd4, 34'h1_5555_AAAA,  2'd0, 1'b0};

      do_reset();

      // constant vector table
      for (int i = 0; i < 12; i++) begin
         i_req_valid   = tbl[i].valid;
         i_req_addr    = tbl[i].addr;
         i_req_data    = tbl[i].data;
         i_clear_start = tbl[i].clr;
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), 64'(o_req_ready), 64'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_wen", i),  64'(o_wenable_reg_a), 64'(tbl[i].wen));
         chk($sformatf("tbl%0d_addr", i), 64'(o_address_reg_a), 64'(tbl[i].waddr));
         chk($sformatf("tbl%0d_data", i), 64'(o_writedata_reg_a), 64'(tbl[i].wdata));
         chk($sformatf("tbl%0d_gid", i),  64'(o_grant_id), 64'(tbl[i].gid));
         chk($sformatf("tbl%0d_busy", i), 64'(o_busy), 64'(tbl[i].busy));
      end

      do_reset();

      // requester 2 waits behind requester 0 and is written exactly once
      pa = {5'd21, 5'd0, 5'd12};
      pd = {34'h2_BEEF_0002, 34'd0, 34'h0_CAFE_0000};
      wcount = 0;
      step(3'b101, pa, pd, 1'b0, "hold0");
      chk("hold_r2_low", 64'(last_dut_rdy[2]), 64'd0);
      step(3'b100, pa, pd, 1'b0, "hold1");
      if (o_wenable_reg_a && o_address_reg_a == 5'd21) wcount++;
      for (int i = 0; i < 3; i++) begin
         step(3'b000, pa, pd, 1'b0, "hold_idle");
         if (o_wenable_reg_a && o_address_reg_a == 5'd21) wcount++;
      end
      chk("hold_single_write", 64'(wcount), 64'd1);

      // clear wins over a simultaneous request; requester 0 gets in on the last busy cycle
      pa = {5'd0, 5'd0, 5'd6};
      pd = {34'd0, 34'd0, 34'h1_0000_0606};
      pv = 3'b001;
      busy_cnt = 0;
      grant_at = -1;
      step(pv, pa, pd, 1'b1, "clr_start");
      chk("clr_start_no_ready", 64'(last_dut_rdy), 64'd0);
      if (o_busy) busy_cnt++;
      for (int i = 0; i < 32; i++) begin
         step(pv, pa, pd, 1'b0, "clr_seq");
         if (o_busy) busy_cnt++;
         if (grant_at < 0 && last_dut_rdy[0]) grant_at = i;
         pv = pv & ~last_rdy;
      end
      chk("clr_busy_len", 64'(busy_cnt), 64'd32);
      chk("clr_grant_cycle", 64'(grant_at), 64'd31);

      // reset in the middle of a clear, then a fresh clear from address 0
      step(3'b000, '0, '0, 1'b1, "mid_clr_start");
      for (int i = 0; i < 9; i++) step(3'b000, '0, '0, 1'b0, "mid_clr");
      #2;
      i_req_valid = '0; i_clear_start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_zero("mid_clr_reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      step(3'b000, '0, '0, 1'b1, "reclr_start");
      chk("reclr_addr0", 64'(o_address_reg_a), 64'd0);
      for (int i = 0; i < 32; i++) step(3'b000, '0, '0, 1'b0, "reclr");

      // randomized traffic obeying the handshake rules
      pv = '0;
      pa = '0;
      pd = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!pv[k] && $urandom_range(0, 1) == 1) begin
               pv[k] = 1'b1;
               pa[k*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
               pd[k*RW +: RW] = {2'($urandom), 32'($urandom)};
            end
         end
         step(pv, pa, pd, ($urandom_range(0, 59) == 0), "rnd");
         pv = pv & ~last_rdy;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
